// File: rtl/cmp_pkg.sv
// Shared definitions for the round-robin comparator arbiter: opcodes, state
// encoding and default operand width.
package cmp_pkg;

    localparam int CMP_DEFAULT_N = 32;

    localparam logic [2:0] CMP_EQ = 3'b000;
    localparam logic [2:0] CMP_NE = 3'b001;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_GE = 3'b011;
    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_LE = 3'b101;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_COMPARE = ST_COMPARE,
        S_RESPOND = ST_RESPOND
    } state_e;

endpackage

// File: rtl/cmp_unit.sv
// Combinational signed comparator: one equality and one greater-than path,
// every other relation derived from those two.
module cmp_unit
    import cmp_pkg::*;
#(
    parameter int N = CMP_DEFAULT_N
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         result,
    output logic         err
);

    logic eq;
    logic gt;

    assign eq = (a == b);
    assign gt = ($signed(a) > $signed(b));

    always_comb begin
        result = 1'b0;
        err    = 1'b0;
        case (op)
            CMP_EQ:  result = eq;
            CMP_NE:  result = ~eq;
            CMP_GT:  result = gt;
            CMP_GE:  result = gt | eq;
            CMP_LT:  result = ~(gt | eq);
            CMP_LE:  result = ~gt;
            default: err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one signed comparator among R requesters,
// returning a tagged 1-bit result on a back-pressurable response port.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int  N   = CMP_DEFAULT_N,
    parameter int  R   = 4,
    localparam int IDW = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [3*R-1:0]   req_op,
    input  logic [N*R-1:0]   req_a,
    input  logic [N*R-1:0]   req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic             rsp_result,
    output logic             rsp_err,
    output logic             busy
);

    logic [2:0]   op_arr [R];
    logic [N-1:0] a_arr  [R];
    logic [N-1:0] b_arr  [R];

    for (genvar gi = 0; gi < R; gi++) begin : g_unpack
        assign op_arr[gi] = req_op[3*gi +: 3];
        assign a_arr[gi]  = req_a[N*gi +: N];
        assign b_arr[gi]  = req_b[N*gi +: N];
    end

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [2:0]     op_q, op_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_result_q, rsp_result_d;
    logic           rsp_err_q, rsp_err_d;
    logic           busy_q, busy_d;

    logic           cmp_result;
    logic           cmp_err;

    cmp_unit #(.N(N)) u_cmp (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (cmp_result),
        .err    (cmp_err)
    );

    // Search from rr_ptr upward, wrapping, for the first valid requester.
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   cand;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < R; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(R)) begin
                cand = cand - (IDW+1)'(R);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    op_d     = op_arr[grant_id];
                    a_d      = a_arr[grant_id];
                    b_d      = b_arr[grant_id];
                    id_d     = grant_id;
                    rr_ptr_d = (grant_id == IDW'(R-1)) ? '0 : grant_id + IDW'(1);
                    state_d  = S_COMPARE;
                end
            end
            S_COMPARE: begin
                rsp_id_d     = id_q;
                rsp_result_d = cmp_result;
                rsp_err_d    = cmp_err;
                rsp_valid_d  = 1'b1;
                state_d      = S_RESPOND;
            end
            S_RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: directed scenarios plus random traffic
// checked against a behavioural round-robin / signed-compare model.
module tb_cmp_arbiter;

    localparam int N   = 32;
    localparam int R   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [R-1:0]     req_valid;
    logic [R-1:0]     req_ready;
    logic [3*R-1:0]   req_op;
    logic [N*R-1:0]   req_a;
    logic [N*R-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_result;
    logic             rsp_err;
    logic             busy;

    cmp_arbiter #(.N(N), .R(R)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic           res;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_ptr = 0;
    bit   outstanding = 0;
    bit   post_rst = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   wait_cnt [R];

    // Reference: signed relations evaluated on plain integers.
    function automatic logic [1:0] ref_cmp(input logic [2:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        int sa;
        int sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        case (op)
            3'd0:    return {1'b0, sa == sbv};
            3'd1:    return {1'b0, sa != sbv};
            3'd2:    return {1'b0, sa >  sbv};
            3'd3:    return {1'b0, sa >= sbv};
            3'd4:    return {1'b0, sa <  sbv};
            3'd5:    return {1'b0, sa <= sbv};
            default: return 2'b10;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [R-1:0] exp_ready;
        int           w;
        int           idx;
        exp_t         e;
        logic [1:0]   r;
        if (!rst_n) begin
            m_ptr = 0;
            sb.delete();
            outstanding = 0;
            post_rst = 1;
            for (int i = 0; i < R; i++) wait_cnt[i] = 0;
        end else begin
            cyc++;
            if (post_rst) begin
                chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
                chk("reset_rsp_id", 64'(rsp_id), 64'd0);
                chk("reset_rsp_result", 64'(rsp_result), 64'd0);
                chk("reset_rsp_err", 64'(rsp_err), 64'd0);
                chk("reset_busy", 64'(busy), 64'd0);
                post_rst = 0;
            end
            exp_ready = '0;
            w = -1;
            if (!outstanding) begin
                for (int k = 0; k < R; k++) begin
                    idx = (m_ptr + k) % R;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("busy", 64'(busy), 64'(outstanding));
            chk("rsp_valid", 64'(rsp_valid), 64'(outstanding && (cyc - acc_cyc >= 2)));
            if (rsp_valid && sb.size() > 0) begin
                e = sb[0];
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_result", 64'(rsp_result), 64'(e.res));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    outstanding = 0;
                end
            end
            if (w >= 0) begin
                r     = ref_cmp(req_op[3*w +: 3], req_a[N*w +: N], req_b[N*w +: N]);
                e.id  = IDW'(w);
                e.err = r[1];
                e.res = r[0];
                sb.push_back(e);
                outstanding = 1;
                acc_cyc = cyc;
                m_ptr = (w + 1) % R;
            end
            for (int i = 0; i < R; i++) begin
                if (req_valid[i] && !exp_ready[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL watchdog requester %0d waited %0d cycles, required <= 200", i, wait_cnt[i]);
                    wait_cnt[i] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(output logic [R-1:0] acc);
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [N-1:0] a,
                           input logic [N-1:0] b);
        req_valid[i]     = 1'b1;
        req_op[3*i +: 3] = op;
        req_a[N*i +: N]  = a;
        req_b[N*i +: N]  = b;
    endtask

    function automatic logic [N-1:0] rval();
        case ($urandom % 4)
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return N'($urandom_range(0, 6)) - N'(3);
            default: return N'($urandom);
        endcase
    endfunction

    task automatic set_rand(input int i);
        logic [N-1:0] a;
        logic [N-1:0] b;
        a = rval();
        b = ($urandom % 4 == 0) ? a : rval();
        set_req(i, 3'($urandom % 8), a, b);
    endtask

    task automatic issue(input int i, input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b);
        logic [R-1:0] acc;
        set_req(i, op, a, b);
        for (int c = 0; c < 60; c++) begin
            tick(acc);
            if (acc[i]) break;
        end
        req_valid[i] = 1'b0;
        for (int c = 0; c < 60 && busy; c++) tick(acc);
    endtask

    task automatic run(input int n, input int pnew, input int pdrop, input int prdy);
        logic [R-1:0] acc;
        for (int c = 0; c < n; c++) begin
            tick(acc);
            for (int i = 0; i < R; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    if (int'($urandom % 100) < pnew) set_rand(i);
                end else if (int'($urandom % 100) < pdrop) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = (int'($urandom % 100) < prdy);
        end
    endtask

    initial begin
        logic [R-1:0] acc;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) tick(acc);
        rst_n = 1'b1;

        issue(2, 3'b010, 32'd5, 32'hFFFF_FFFD);
        issue(0, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF);
        issue(0, 3'b010, 32'h8000_0000, 32'h7FFF_FFFF);
        issue(3, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(1, 3'b111, 32'd1, 32'd2);

        // Back-pressure with another requester waiting
        rsp_ready = 1'b0;
        set_req(3, 3'b101, 32'h10, 32'h10);
        for (int c = 0; c < 20; c++) begin
            tick(acc);
            if (acc[3]) break;
        end
        req_valid[3] = 1'b0;
        set_req(0, 3'b000, 32'd7, 32'd7);
        repeat (7) tick(acc);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(acc);
            if (acc[0]) break;
        end
        req_valid[0] = 1'b0;
        for (int c = 0; c < 60 && busy; c++) tick(acc);

        // Reset while in COMPARE
        set_req(2, 3'b011, 32'd9, 32'd4);
        for (int c = 0; c < 20; c++) begin
            tick(acc);
            if (acc[2]) break;
        end
        rst_n     = 1'b0;
        req_valid = '0;
        tick(acc);
        rst_n = 1'b1;
        set_req(1, 3'b100, 32'd1, 32'd2);
        set_req(3, 3'b100, 32'd3, 32'd2);
        for (int c = 0; c < 20; c++) begin
            tick(acc);
            if (acc != '0) break;
        end
        req_valid = '0;
        for (int c = 0; c < 60 && busy; c++) tick(acc);

        // Fairness from reset: all requesters continuously valid
        rst_n     = 1'b0;
        req_valid = '0;
        tick(acc);
        rst_n = 1'b1;
        for (int i = 0; i < R; i++) set_rand(i);
        run(15, 100, 0, 100);

        // Random traffic with back-pressure and withdrawals
        run(600, 40, 10, 70);

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) tick(acc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shares one signed N-bit comparator among R requesters with round-robin arbitration. Each requester presents an opcode and two operands with a valid/ready handshake; the block registers the winner's operands, evaluates the comparison, and returns a 1-bit result tagged with the requester index on a shared, back-pressurable response port. It sits between the issue logic of several ALU lanes and the single comparator bank, so a comparator is not replicated per lane.

## Interface
- N, 32: operand width in bits, two's complement.
- R, 4: number of requesters, at least 2.
- IDW, $clog2(R): requester index width. Derived from R; never overridden.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  R  per-requester request valid.
- req_ready  out  R  per-requester accept; at most one bit high per cycle.
- req_op  in  3*R  opcode of requester i in bits [3i+2:3i].
- req_a  in  N*R  operand A of requester i in bits [N*i+N-1:N*i].
- req_b  in  N*R  operand B of requester i, same packing as req_a.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_result  out  1  comparison outcome.
- rsp_err  out  1  the opcode was illegal.
- busy  out  1  the FSM is not in IDLE.

## Operation
- Opcodes: 000 EQ (a==b); 001 NE; 010 GT (a>b); 011 GE; 100 LT; 101 LE. Comparisons are signed.
- Opcodes 110 and 111 are illegal: rsp_result=0 and rsp_err=1, and the request is still consumed and answered.
- FSM states are IDLE, COMPARE and RESPOND.
- IDLE:
  - If any req_valid bit is set, assert req_ready for the winner only.
  - The winner is the first requester with req_valid set, searching from rr_ptr upward and wrapping at R-1 to 0.
  - On the handshake: capture op, a, b and the index into registers, set rr_ptr to (winner+1) mod R, and go to COMPARE.
- COMPARE:
  - The comparator evaluates the registered operands.
  - The result, the error flag and the index are registered into the rsp_* registers, and the FSM goes to RESPOND.
  - No req_ready is asserted in this state.
- RESPOND:
  - rsp_valid=1. rsp_id, rsp_result and rsp_err stay stable until rsp_valid & rsp_ready.
  - On that handshake go to IDLE.
- req_ready is 0 in COMPARE and RESPOND. A requester that deasserts req_valid before it is granted loses nothing.
- Requests are never reordered: a requester's next request is not accepted until its previous response handshake completes.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0, rr_ptr=0, state=IDLE.
- Reset mid-operation drops any in-flight request silently; no response is produced for it.

## Timing
- Accept handshake in cycle T: rsp_valid rises at the edge ending T+1 and is visible during T+2. Latency is 2 cycles.
- Minimum occupancy is 3 cycles per request: accept, compare, and respond with rsp_ready held high. Throughput is therefore at most one request per 3 cycles.
- req_ready is combinational from state, rr_ptr and req_valid. It has no combinational path from rsp_ready.
- rsp_* outputs and busy come directly from flops.
- Stalled rsp_ready holds RESPOND indefinitely. Requests arriving meanwhile wait in their requesters.
- The comparator path (N-bit signed compare) is the only long path and lies flop-to-flop in COMPARE.

## Structure
- Shared package cmp_pkg holds:
  - opcode constants CMP_EQ, CMP_NE, CMP_GT, CMP_GE, CMP_LT, CMP_LE;
  - the state encoding localparams ST_IDLE, ST_COMPARE, ST_RESPOND;
  - the default width 32.
- One combinational sub-module, cmp_unit (parameter N):
  - inputs op, a, b; outputs result and err;
  - built from a single signed equality path and a single signed greater-than path;
  - NE, GE, LT and LE are derived from those two.
- The round-robin search stays inline in cmp_arbiter.

## Test plan
- Single request: req_valid[2]=1, op=010, a=5, b=-3.
  - Expect req_ready[2]=1 in the first cycle and rsp_valid two cycles later.
  - Expect rsp_id=2, rsp_result=1, rsp_err=0.
- Fairness, R=4: all four req_valid held high with rsp_ready=1 from reset. Expect grant order 0,1,2,3,0 and each response 3 cycles apart.
- Signed boundaries:
  - a=32'h8000_0000, b=32'h7FFF_FFFF with op LT gives 1; with op GT gives 0.
  - a=b=-1 with op GE gives 1, with op NE gives 0, with op EQ gives 1.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_* stay stable, req_ready stays 0 throughout, and busy=1.
  - Release with rsp_ready=1: state returns to IDLE the next cycle.
- Illegal opcode: op=111 from requester 1. Expect rsp_result=0, rsp_err=1, rsp_id=1, and the handshake completes normally.
- Reset mid-operation: rst_n=0 for 1 cycle while in COMPARE.
  - Expect no response, all outputs at reset values, and rr_ptr=0.
  - The next grant goes to the lowest-index valid requester.
